// File: rtl/vga_axil_pkg.sv
// Shared AXI-Lite / native-side types used across the VGA control-register path.
package vga_axil_pkg;
  typedef logic [31:0] axil_data_t;
  typedef logic [7:0]  native_addr_t;
endpackage

// File: rtl/vga_reg_arb_pkg.sv
// Types shared by the VGA register-bank arbiter, its interface and its bank.
package vga_reg_arb_pkg;
  typedef vga_axil_pkg::axil_data_t   axil_data_t;
  typedef vga_axil_pkg::native_addr_t native_addr_t;

  localparam int BANK_WORDS = 2 ** $bits(native_addr_t);

  typedef struct packed {
    native_addr_t addr;
    axil_data_t   data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    GrantNone,
    GrantHostRd,
    GrantDrain,
    GrantInt
  } arb_grant_e;
endpackage

// File: rtl/vga_reg_arbiter_if.sv
// Host and internal-requester signals of the register arbiter. Internal side is
// valid/ready: a transfer happens in a cycle where int_valid_i and int_ready_o are both high.
interface vga_reg_arbiter_if;
  import vga_reg_arb_pkg::*;

  logic         host_write_en_i;
  native_addr_t host_addr_write_i;
  axil_data_t   host_wdata_i;
  logic         host_read_en_i;
  native_addr_t host_addr_read_i;
  axil_data_t   host_rdata_o;
  logic         int_valid_i;
  native_addr_t int_addr_i;
  logic         int_ready_o;
  logic         int_rvalid_o;
  axil_data_t   int_rdata_o;
  logic         overflow_o;

  modport master (
    output host_write_en_i, host_addr_write_i, host_wdata_i,
    output host_read_en_i, host_addr_read_i,
    output int_valid_i, int_addr_i,
    input  host_rdata_o, int_ready_o, int_rvalid_o, int_rdata_o, overflow_o
  );

  modport slave (
    input  host_write_en_i, host_addr_write_i, host_wdata_i,
    input  host_read_en_i, host_addr_read_i,
    input  int_valid_i, int_addr_i,
    output host_rdata_o, int_ready_o, int_rvalid_o, int_rdata_o, overflow_o
  );
endinterface

// File: rtl/vga_reg_bank.sv
// Single-port register bank with a registered (1-cycle) read. Contents survive reset.
module vga_reg_bank
  import vga_reg_arb_pkg::*;
(
  input  logic         clk_i,
  input  logic         en_i,
  input  logic         we_i,
  input  native_addr_t addr_i,
  input  axil_data_t   wdata_i,
  output axil_data_t   rdata_o
);
  axil_data_t mem_q [BANK_WORDS];
  axil_data_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_reg_arbiter.sv
// Arbitrates the single bank port between host reads, a host write buffer and the
// internal requester. Optional starvation guard enabled by VGA_REG_ARB_STARVE_EN.
module vga_reg_arbiter
  import vga_reg_arb_pkg::*;
#(
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vga_reg_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      wbuf_q [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, fwd_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             host_pend_q, int_pend_q, fwd_hit_q, fwd_hit;
  axil_data_t       fwd_data_q, fwd_data, host_hold_q, int_hold_q;
  axil_data_t       bank_rdata, read_data;
  native_addr_t     bank_addr;
  arb_grant_e       grant;
  logic             full, empty, push, pop, drop, starved;

  assign full  = (count_q == CNT_W'(WBUF_DEPTH));
  assign empty = (count_q == '0);

`ifdef VGA_REG_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_q, starve_d;

  assign starved = (starve_q >= SC_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!bus.int_valid_i || grant == GrantInt) starve_d = '0;
    else if (!starved)                         starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starved = 1'b0;
`endif

  always_comb begin
    grant = GrantNone;
    if (bus.host_read_en_i)               grant = GrantHostRd;
    else if (full)                        grant = GrantDrain;
    else if (starved && bus.int_valid_i)  grant = GrantInt;
    else if (!empty)                      grant = GrantDrain;
    else if (bus.int_valid_i)             grant = GrantInt;
  end

  // A full buffer only has room for a new write when the drain runs this cycle.
  assign pop  = (grant == GrantDrain);
  assign push = bus.host_write_en_i && (!full || pop);
  assign drop = bus.host_write_en_i && !push;

  always_comb begin
    bank_addr = wbuf_q[rd_ptr_q].addr;
    if (grant == GrantHostRd)   bank_addr = bus.host_addr_read_i;
    else if (grant == GrantInt) bank_addr = bus.int_addr_i;
  end

  // Oldest-to-youngest scan so the youngest match wins; a same-cycle write is youngest of all.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && wbuf_q[fwd_idx].addr == bank_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = wbuf_q[fwd_idx].data;
      end
    end
    if (push && bus.host_addr_write_i == bank_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.host_wdata_i;
    end
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | drop;
  end

  vga_reg_bank u_bank (
    .clk_i   (clk_i),
    .en_i    ((grant != GrantNone) && !rst_i),
    .we_i    (pop),
    .addr_i  (bank_addr),
    .wdata_i (wbuf_q[rd_ptr_q].data),
    .rdata_o (bank_rdata)
  );

  assign read_data = fwd_hit_q ? fwd_data_q : bank_rdata;

  always_ff @(posedge clk_i) begin
    if (push) wbuf_q[wr_ptr_q] <= '{addr: bus.host_addr_write_i, data: bus.host_wdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      host_pend_q <= 1'b0;
      int_pend_q  <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      host_hold_q <= '0;
      int_hold_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      host_pend_q <= (grant == GrantHostRd);
      int_pend_q  <= (grant == GrantInt);
      fwd_hit_q   <= fwd_hit;
      fwd_data_q  <= fwd_data;
      if (host_pend_q) host_hold_q <= read_data;
      if (int_pend_q)  int_hold_q  <= read_data;
    end
  end

  assign bus.host_rdata_o = host_pend_q ? read_data : host_hold_q;
  assign bus.int_rdata_o  = int_pend_q  ? read_data : int_hold_q;
  assign bus.int_rvalid_o = int_pend_q;
  assign bus.int_ready_o  = (grant == GrantInt) && !rst_i;
  assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_vga_reg_arbiter.sv
// Self-checking bench for vga_reg_arbiter against a queue/array reference model.
module tb_vga_reg_arbiter;
  import vga_reg_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef VGA_REG_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_reg_arbiter_if bus ();

  vga_reg_arbiter #(.WBUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // reference model
  axil_data_t  bank_m [BANK_WORDS];
  wbuf_entry_t wq [$];
  logic [31:0] exp_q [$];
  axil_data_t  host_exp, int_exp;
  logic        ovf_m, rv_m;
  int          starve_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic axil_data_t model_read(input native_addr_t a, input bit acc,
                                            input native_addr_t wa, input axil_data_t wd);
    axil_data_t v;
    v = bank_m[a];
    foreach (wq[i]) if (wq[i].addr == a) v = wq[i].data;
    if (acc && wa == a) v = wd;
    return v;
  endfunction

  task automatic model_reset();
    wq.delete();
    exp_q.delete();
    host_exp = '0;
    int_exp  = '0;
    ovf_m    = 1'b0;
    rv_m     = 1'b0;
    starve_m = 0;
  endtask

  // One bus cycle: drive after a negedge, check combinational ready, advance, check outputs.
  task automatic step(input bit rd, input native_addr_t raddr, input bit we,
                      input native_addr_t waddr, input axil_data_t wdata,
                      input bit iv, input native_addr_t iaddr, output arb_grant_e g);
    bit full, acc;
    wbuf_entry_t e;
    bus.host_read_en_i    = rd;
    bus.host_addr_read_i  = raddr;
    bus.host_write_en_i   = we;
    bus.host_addr_write_i = waddr;
    bus.host_wdata_i      = wdata;
    bus.int_valid_i       = iv;
    bus.int_addr_i        = iaddr;
    #1;
    full = (wq.size() == DEPTH);
    if (rd)                                   g = GrantHostRd;
    else if (full)                            g = GrantDrain;
    else if (STARVE_ON && starve_m >= LIMIT && iv) g = GrantInt;
    else if (wq.size() != 0)                  g = GrantDrain;
    else if (iv)                              g = GrantInt;
    else                                      g = GrantNone;
    check("int_ready", {31'b0, bus.int_ready_o}, {31'b0, g == GrantInt});
    acc = we && (!full || g == GrantDrain);
    if (g == GrantHostRd) exp_q.push_back(model_read(raddr, acc, waddr, wdata));
    rv_m = (g == GrantInt);
    if (rv_m) int_exp = model_read(iaddr, acc, waddr, wdata);
    if (g == GrantDrain) begin
      e = wq.pop_front();
      bank_m[e.addr] = e.data;
    end
    if (acc) wq.push_back('{addr: waddr, data: wdata});
    if (we && !acc) ovf_m = 1'b1;
    if (!iv || g == GrantInt) starve_m = 0;
    else                      starve_m++;
    @(negedge clk);
    if (exp_q.size() != 0) host_exp = exp_q.pop_front();
    check("host_rdata", bus.host_rdata_o, host_exp);
    check("int_rvalid", {31'b0, bus.int_rvalid_o}, {31'b0, rv_m});
    if (rv_m) check("int_rdata", bus.int_rdata_o, int_exp);
    check("overflow", {31'b0, bus.overflow_o}, {31'b0, ovf_m});
  endtask

  task automatic idle(input int n);
    arb_grant_e g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_read_en_i = 0; bus.host_write_en_i = 0;
    bus.host_addr_read_i = 0; bus.host_addr_write_i = 0; bus.host_wdata_i = 0;
    bus.int_valid_i = 1'b1; bus.int_addr_i = 8'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_int_ready", {31'b0, bus.int_ready_o}, 32'd0);
    rst = 1'b0;
    bus.int_valid_i = 1'b0;
    model_reset();
    #1;
    check("rst_host_rdata", bus.host_rdata_o, 32'd0);
    check("rst_int_rdata",  bus.int_rdata_o,  32'd0);
    check("rst_int_rvalid", {31'b0, bus.int_rvalid_o}, 32'd0);
    check("rst_overflow",   {31'b0, bus.overflow_o},   32'd0);
    @(negedge clk);
  endtask

  function automatic native_addr_t pool_addr();
    return native_addr_t'({$urandom_range(0, 15), 2'b00});
  endfunction

  initial begin
    arb_grant_e   g;
    bit           granted, ipend;
    native_addr_t iaddr;
    model_reset();
    do_reset();

    // give every pool address a known bank value
    for (int i = 0; i < 16; i++) step(0, 0, 1, native_addr_t'(i * 4), $urandom, 0, 0, g);
    idle(3);

    // write drains, later read sees it with 1-cycle latency
    step(0, 0, 1, 8'h04, 32'hA5A5_0001, 0, 0, g);
    idle(3);
    step(1, 8'h04, 0, 0, 0, 0, 0, g);
    check("plan_rd_04", bus.host_rdata_o, 32'hA5A5_0001);
    idle(1);

    // same-cycle write/read forwarding
    step(1, 8'h08, 1, 8'h08, 32'h0000_1234, 0, 0, g);
    check("plan_fwd_08", bus.host_rdata_o, 32'h0000_1234);
    idle(2);

    // host reads hold off the internal requester
    for (int i = 0; i < 5; i++) step(1, pool_addr(), 0, 0, 0, 1, 8'h0C, g);
    step(0, 0, 0, 0, 0, 1, 8'h0C, g);
    check("plan_int_grant", {30'b0, g}, {30'b0, GrantInt});
    idle(2);

    // drain vs internal request with occupancy held at one
    step(0, 0, 1, 8'h20, $urandom, 0, 0, g);
    granted = 1'b0;
    for (int i = 0; i < 6 && !granted; i++) begin
      step(0, 0, 1, pool_addr(), $urandom, 1, 8'h14, g);
      granted = (g == GrantInt);
    end
    for (int i = 0; i < 10 && !granted; i++) begin
      step(0, 0, 0, 0, 0, 1, 8'h14, g);
      granted = (g == GrantInt);
    end
    check("int_eventually_granted", {31'b0, granted}, 32'd1);
    idle(4);

    // full buffer + host read + host write -> dropped, sticky overflow
    for (int i = 0; i < 3; i++) step(1, 8'h00, 1, pool_addr(), $urandom, 0, 0, g);
    idle(3);
    check("overflow_sticky", {31'b0, bus.overflow_o}, 32'd1);

    // reset with two buffered writes: they are lost, bank keeps old values
    step(1, 8'h00, 1, 8'h10, 32'hDEAD_0010, 0, 0, g);
    step(1, 8'h00, 1, 8'h14, 32'hDEAD_0014, 0, 0, g);
    do_reset();
    step(1, 8'h10, 0, 0, 0, 0, 0, g);
    step(1, 8'h14, 0, 0, 0, 0, 0, g);
    idle(1);

    // randomized traffic
    ipend = 1'b0;
    iaddr = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1'b1;
        iaddr = pool_addr();
      end
      step($urandom_range(0, 2) == 0, pool_addr(), $urandom_range(0, 2) == 0,
           pool_addr(), $urandom, ipend, iaddr, g);
      if (g == GrantInt) ipend = 1'b0;
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_reg_arbiter.md
# vga_reg_arbiter

Single-port register-bank controller for the VGA control registers. Sits between the native side of `vga_axil_slave_fsm` (host) and a single-port, 1-cycle-read register bank. The bank is shared with the internal display-core requester. Host reads are never stalled; host writes are absorbed by a small write buffer with read forwarding; the internal requester uses a valid/ready handshake at lowest priority.

## Interface
- `WBUF_DEPTH`, 2: write-buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: internal wait cycles before it beats buffer drain (macro-gated).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `host_write_en_i` in 1: host write strobe (from `write_en_o`).
- `host_addr_write_i` in `native_addr_t`: host write address.
- `host_wdata_i` in `axil_data_t`: host write data.
- `host_read_en_i` in 1: host read strobe (from `read_en_sync_o`).
- `host_addr_read_i` in `native_addr_t`: host read address.
- `host_rdata_o` out `axil_data_t`: read data to slave FSM `data_i`.
- `int_valid_i` in 1: internal read request.
- `int_addr_i` in `native_addr_t`: internal read address.
- `int_ready_o` out 1: internal request granted this cycle.
- `int_rvalid_o` out 1: internal read data valid.
- `int_rdata_o` out `axil_data_t`: internal read data.
- `overflow_o` out 1: sticky error; a host write was dropped.

## Operation
- Port grant per cycle, highest first:
  - host read;
  - buffer drain if buffer full;
  - internal request (only if starved, see Configuration);
  - buffer drain if not empty;
  - internal request.
- Host write: always enqueued into the FIFO buffer on `host_write_en_i`, then drained oldest-first through the bank port.
- Host write and drain in the same cycle: both occur; occupancy is unchanged.
- Host write on a full buffer while the port is taken by a host read: the write is dropped and `overflow_o` is set until reset.
- Host write on a full buffer when the port is free: the drain frees a slot in that cycle, so no overflow occurs.
- Read forwarding: host and internal reads compare their address against all valid buffer entries. The youngest matching entry's data replaces the bank data.
- A write enqueued in the same cycle as a read to the same address is forwarded to that read, so write-then-read ordering holds.
- Internal request: `int_ready_o` is asserted combinationally on grant. A request held low-priority keeps `int_valid_i`/`int_addr_i` stable until granted.
- No internal request is queued; no back-to-back limit applies.
- Buffer pointers wrap modulo `WBUF_DEPTH`. Occupancy counter is `$clog2(WBUF_DEPTH)+1` bits wide.

## Timing
- Host read latency: 1 cycle. `host_rdata_o` is valid the cycle after `host_read_en_i` and holds until the next host read.
- Internal read latency: 1 cycle. `int_rvalid_o` pulses for one cycle, the cycle after `int_ready_o`.
- A buffered write becomes visible in the bank the cycle after its drain. Until then it is visible only through forwarding.
- Reset values: `host_rdata_o`=0, `int_rdata_o`=0, `int_ready_o`=0, `int_rvalid_o`=0, `overflow_o`=0. Buffer empty, starvation counter 0.
- Reset mid-operation: all buffered writes are discarded and in-flight rvalid is cancelled. Bank contents are not cleared.

## Configuration
- `VGA_REG_ARB_STARVE_EN` defined: a counter increments each cycle `int_valid_i` is high without grant.
  - At `STARVE_LIMIT` the internal request outranks non-full drain.
  - The counter clears on grant.
- `VGA_REG_ARB_STARVE_EN` not defined: there is no counter, and a non-empty drain always beats the internal request.

## Structure
- Shared package `vga_reg_arb_pkg`, which imports `axil_data_t` and `native_addr_t` from `vga_axil_pkg`. It holds:
  - `wbuf_entry_t` (addr, data);
  - `arb_grant_e` (`GrantNone`, `GrantHostRd`, `GrantDrain`, `GrantInt`).
- Sub-module `vga_reg_bank`: single-port, synchronous-read RAM (en, we, addr, wdata, rdata) instantiated once.
- Grant logic, buffer, forwarding mux and output registers stay in the top module.

## Test plan
- Host write 0xA5A5_0001 to 0x04, no reads → drained next cycle; a host read of 0x04 three cycles later returns 0xA5A5_0001 with 1-cycle latency.
- Host write 0x1234 to 0x08 in the same cycle as a host read of 0x08 → `host_rdata_o`=0x1234 the next cycle (forwarded).
- `int_valid_i` held with `int_addr_i`=0x0C while the host reads every cycle for 5 cycles → `int_ready_o` stays 0 until the first idle host cycle. `int_rvalid_o` follows one cycle after grant.
- `VGA_REG_ARB_STARVE_EN`, `STARVE_LIMIT`=4, buffer kept non-full and non-empty, internal request pending → granted on the 5th cycle ahead of the drain.
- Buffer full (2 entries) plus a host read plus a host write in the same cycle → write dropped; `overflow_o`=1 and stays 1 until `rst_i`.
- Assert `rst_i` with 2 buffered writes → buffer empty and outputs 0. A read of those addresses returns the pre-write bank values.
